// File: rtl/key_debouncer.sv
// key_debouncer: conditions four raw active-low push-buttons for the button PIO.
// Each key is synchronised, then debounced by its own small state machine.
// Keys whose REPEAT_MASK bit is set also generate auto-repeat edges while held.
// btn_n and held are registered from the next-state decode, so they move on the
// same edge as the state.

module key_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_GAP      = 4,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic btn_n,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_GAP,
    S_REPEAT,
    S_RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REPEAT_GAP - 1);

  logic             s1, s2;
  logic             sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             btn_nxt, held_nxt;

  assign sync = s2;

  // Two-flop synchroniser; resets to the released level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nxt = state;
    // Saturating increment: a held key with repeat disabled just parks here
    cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    cnt_nxt   = cnt_inc;
    btn_nxt   = 1'b1;
    held_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!sync) state_nxt = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (sync)                 state_nxt = S_IDLE;
        else if (cnt == DB_LAST)  state_nxt = S_HELD;
      end
      S_HELD: begin
        if (sync)                             state_nxt = S_RELEASE_WAIT;
        else if (REPEAT_EN && cnt == RD_LAST) state_nxt = S_GAP;
      end
      S_GAP: begin
        // The gap always runs to completion so the PIO sees a full-width pulse
        if (cnt == GAP_LAST) state_nxt = S_REPEAT;
      end
      S_REPEAT: begin
        if (sync)                state_nxt = S_RELEASE_WAIT;
        else if (cnt == RP_LAST) state_nxt = S_GAP;
      end
      S_RELEASE_WAIT: begin
        // Re-press restarts HELD, and with it the repeat delay
        if (!sync)               state_nxt = S_HELD;
        else if (cnt == DB_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    case (state_nxt)
      S_HELD, S_REPEAT, S_RELEASE_WAIT: begin
        btn_nxt  = 1'b0;
        held_nxt = 1'b1;
      end
      S_GAP: begin
        btn_nxt  = 1'b1;
        held_nxt = 1'b1;
      end
      default: begin
        btn_nxt  = 1'b1;
        held_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      btn_n <= 1'b1;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      btn_n <= btn_nxt;
      held  <= held_nxt;
    end
  end

endmodule

module key_debouncer #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 15000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter int         REPEAT_GAP      = 4,
  parameter logic [3:0] REPEAT_MASK     = 4'b0111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] btn_n,
  output logic [3:0] held
);

  localparam int NUM_KEYS = 4;
  localparam int MAX_AB   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CD   = (REPEAT_PERIOD > REPEAT_GAP) ? REPEAT_PERIOD : REPEAT_GAP;
  localparam int MAX_CYC  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // One independent debouncer per key
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_GAP      (REPEAT_GAP),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (key_n[i]),
      .btn_n   (btn_n[i]),
      .held    (held[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with short timing parameters.
// Edge e of each scenario is the e-th rising clk after the inputs for it are set;
// outputs are sampled 1 time unit after that edge.

module tb_key_debouncer;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] btn_n;
  logic [3:0] held;

  int checks = 0;
  int errors = 0;

  key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (6),
    .REPEAT_GAP      (2),
    .REPEAT_MASK     (4'b0111)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .btn_n   (btn_n),
    .held    (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple PIO falling-edge capture: two-stage detector, sticky capture bit,
  // irq while set, cleared by a one-cycle write strobe.
  logic pio_d1, pio_d2, pio_cap, cap_clr;
  logic pio_irq;
  assign pio_irq = pio_cap;

  always @(posedge clk) begin
    if (!reset_n) begin
      pio_d1  <= 1'b1;
      pio_d2  <= 1'b1;
      pio_cap <= 1'b0;
    end else begin
      pio_d1  <= btn_n[1];
      pio_d2  <= pio_d1;
      pio_cap <= (pio_cap & ~cap_clr) | (pio_d2 & ~pio_d1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_n   = 4'hF;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_b;
    reset_n = 1'b0;
    key_n   = 4'h0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (btn_n !== 4'hF || held !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold c%0d: btn_n=%h held=%h, expected btn_n=f held=0", c, btn_n, held);
      end
    end
    reset_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      cyc();
      exp_b = (e >= 6) ? 4'h0 : 4'hF;
      checks++;
      if (btn_n !== exp_b || held !== ~exp_b) begin
        errors++;
        $display("FAIL reset_release e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, ~exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [3:0] exp_b;
    do_reset();
    key_n = 4'hE;
    for (int e = 0; e <= 16; e++) cyc();
    // After edge 16 key 0 is in its first repeat gap
    checks++;
    if (btn_n !== 4'hF || held !== 4'h1) begin
      errors++;
      $display("FAIL gap_before_reset: btn_n=%h held=%h, expected btn_n=f held=1", btn_n, held);
    end
    reset_n = 1'b0;
    cyc();
    checks++;
    if (btn_n !== 4'hF || held !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_gap: btn_n=%h held=%h, expected btn_n=f held=0", btn_n, held);
    end
    reset_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      cyc();
      exp_b = (e >= 6) ? 4'hE : 4'hF;
      checks++;
      if (btn_n !== exp_b || held !== ~exp_b) begin
        errors++;
        $display("FAIL reset_mid_repress e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, ~exp_b);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_b;
    do_reset();
    for (int e = 0; e <= 15; e++) begin
      // low 3, high 1, low 2, high 1, then steady low from edge 7
      key_n    = 4'hF;
      key_n[1] = (e == 3 || e == 6);
      cyc();
      exp_b    = 4'hF;
      exp_b[1] = (e < 13);
      checks++;
      if (btn_n !== exp_b || held !== ~exp_b) begin
        errors++;
        $display("FAIL bounce e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, ~exp_b);
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] exp_b, exp_h;
    int d;
    do_reset();
    for (int e = 0; e <= 46; e++) begin
      key_n = 4'hE;
      cyc();
      exp_b = 4'hF;
      exp_h = 4'h0;
      if (e >= 6) begin
        d = e - 6;
        exp_h[0] = 1'b1;
        exp_b[0] = (d >= 10) && (((d - 10) % 8) < 2);
      end
      checks++;
      if (btn_n !== exp_b || held !== exp_h) begin
        errors++;
        $display("FAIL repeat e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, exp_h);
      end
    end
  endtask

  task automatic test_no_repeat();
    logic [3:0] exp_b;
    do_reset();
    for (int e = 0; e <= 58; e++) begin
      key_n = (e >= 47) ? 4'hF : 4'h7;
      cyc();
      exp_b    = 4'hF;
      exp_b[3] = !(e >= 6 && e < 53);
      checks++;
      if (btn_n !== exp_b || held !== ~exp_b) begin
        errors++;
        $display("FAIL no_repeat e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, ~exp_b);
      end
    end
  endtask

  task automatic test_gap_release();
    logic [3:0] exp_b, exp_h;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      key_n    = 4'hF;
      key_n[0] = (e >= 15);
      key_n[2] = (e < 15);
      cyc();
      exp_b    = 4'hF;
      exp_h    = 4'h0;
      exp_b[0] = (e < 6) || (e == 16) || (e == 17) || (e >= 23);
      exp_h[0] = (e >= 6) && (e < 23);
      exp_b[2] = (e < 21);
      exp_h[2] = (e >= 21);
      checks++;
      if (btn_n !== exp_b || held !== exp_h) begin
        errors++;
        $display("FAIL gap_release e%0d: btn_n=%h held=%h, expected btn_n=%h held=%h",
                 e, btn_n, held, exp_b, exp_h);
      end
    end
  endtask

  task automatic test_pio();
    int irq_cnt;
    irq_cnt = 0;
    do_reset();
    for (int e = 0; e <= 45; e++) begin
      key_n   = (e < 30) ? 4'hD : 4'hF;
      cap_clr = pio_irq;
      if (pio_irq) irq_cnt++;
      cyc();
    end
    cap_clr = 1'b0;
    // Initial press plus repeats ending at edges 18 and 26
    checks++;
    if (irq_cnt !== 3) begin
      errors++;
      $display("FAIL pio_irq_count: got %0d, expected 3", irq_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 4'hF;
    cap_clr = 1'b0;
    test_reset();
    test_reset_mid_gap();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_gap_release();
    test_pio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
